// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte producers.
// Optional grant-hold (multi-byte messages) is built when UART_TX_SCHED_LOCK_EN is defined.
module uart_tx_sched #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [8*N_REQ-1:0]         i_data,
  input  logic [N_REQ-1:0]           i_lock,
  output logic [N_REQ-1:0]           o_ack,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_data,
  input  logic                       i_tx_busy,
  input  logic                       i_tx_done,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic                       o_sched_busy,
  output logic [CNT_W-1:0]           o_byte_cnt
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [N_REQ-1:0]  r_ack;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic [ID_W-1:0]   r_grant_id;
  logic              r_busy;
  logic [CNT_W-1:0]  r_byte_cnt;

  logic [7:0]        w_bytes [N_REQ];
  logic [N_REQ-1:0]  w_req_eff;
  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign w_bytes[gi] = i_data[8*gi +: 8];
    end
  endgenerate

`ifdef UART_TX_SCHED_LOCK_EN
  logic              r_lock_vld;
  logic [ID_W-1:0]   r_lock_id;
  logic              w_lock_hold;

  // While the owner keeps its lock high only the owner is eligible.
  assign w_lock_hold = r_lock_vld & i_lock[r_lock_id];
  assign w_req_eff   = w_lock_hold ? (i_req & (N_REQ'(1) << r_lock_id)) : i_req;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^i_lock;
  assign w_req_eff     = i_req;
`endif

  // Scan from the farthest distance down so the nearest requester after r_ptr wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = ID_W'((int'(r_ptr) + i) % N_REQ);
      if (w_req_eff[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= ID_W'(N_REQ - 1);
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_byte_cnt <= '0;
`ifdef UART_TX_SCHED_LOCK_EN
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
`endif
    end else begin
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef UART_TX_SCHED_LOCK_EN
          if (r_lock_vld && !i_lock[r_lock_id]) r_lock_vld <= 1'b0;
`endif
          if (w_found) begin
            r_tx_data  <= w_bytes[w_winner];
            r_ack      <= N_REQ'(1) << w_winner;
            r_grant_id <= w_winner;
            r_ptr      <= w_winner;
            r_busy     <= 1'b1;
            r_state    <= S_START;
`ifdef UART_TX_SCHED_LOCK_EN
            r_lock_vld <= i_lock[w_winner];
            r_lock_id  <= w_winner;
`endif
          end
        end
        S_START: begin
          r_tx_start <= 1'b1;
          r_state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A very short frame may finish before busy is ever seen.
          if (i_tx_done) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else if (i_tx_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (i_tx_done) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ack        = r_ack;
  assign o_tx_start   = r_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_grant_id   = r_grant_id;
  assign o_sched_busy = r_busy;
  assign o_byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: transaction-level reference model, behavioural transmitter,
// directed scenarios followed by randomized producer traffic.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     lock = '0;
  logic [8*N-1:0]   data = '0;
  logic             tx_busy = 1'b0;
  logic             tx_done = 1'b0;
  logic [N-1:0]     ack;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [IW-1:0]    gid;
  logic             sbusy;
  logic [CW-1:0]    bcnt;

  always #5 clk = ~clk;

  uart_tx_sched #(.N_REQ(N), .CNT_W(CW)) dut (
    .i_clk(clk), .rst(rst), .i_req(req), .i_data(data), .i_lock(lock),
    .o_ack(ack), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .i_tx_busy(tx_busy), .i_tx_done(tx_done),
    .o_grant_id(gid), .o_sched_busy(sbusy), .o_byte_cnt(bcnt)
  );

  // Reference model: a transfer is "active" from its grant until the first done
  // seen two or more cycles after the grant; busy never matters to it.
  bit          m_active;
  int          m_age, m_last, m_gid, m_cnt, m_owner;
  logic [7:0]  m_data;
  int          total = 0, bad = 0, nxfer = 0;
  int          tx_t = -1, frame = 10;
  bit          short_mode = 1'b0, rand_tx = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_age = 0; m_last = N - 1; m_gid = 0;
    m_cnt = 0; m_owner = -1; m_data = '0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r);
    int idx;
    for (int d = 1; d <= N; d++) begin
      idx = (m_last + d) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Called once per falling edge: advance model with the inputs of the last cycle,
  // compare, then let the transmitter model react.
  task automatic step();
    logic [N-1:0] e_ack;
    bit e_start, locked;
    int w;
    e_ack = '0; e_start = 1'b0; locked = 1'b0; w = -1;
    if (!rst) model_reset();
    else if (!m_active) begin
`ifdef UART_TX_SCHED_LOCK_EN
      if (m_owner >= 0 && lock[m_owner]) locked = 1'b1;
      else m_owner = -1;
`endif
      if (locked) w = req[m_owner] ? m_owner : -1;
      else w = rr_pick(req);
      if (w >= 0) begin
        e_ack[w] = 1'b1; m_active = 1'b1; m_age = 0;
        m_last = w; m_gid = w; m_data = data[8*w +: 8];
`ifdef UART_TX_SCHED_LOCK_EN
        m_owner = lock[w] ? w : -1;
`endif
        nxfer++;
        $display("xfer %0d: grant=%0d byte=%02h cnt=%0d t=%0t", nxfer, w, m_data, m_cnt, $time);
      end
    end else begin
      m_age++;
      if (m_age == 1) e_start = 1'b1;
      else if (tx_done) begin
        m_active = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
    chk("ack", 32'(ack), 32'(e_ack));
    chk("tx_start", 32'(tx_start), 32'(e_start));
    chk("sched_busy", 32'(sbusy), 32'(m_active));
    chk("byte_cnt", 32'(bcnt), m_cnt);
    chk("grant_id", 32'(gid), m_gid);
    chk("tx_data", 32'(tx_data), 32'(m_data));

    if (!rst) begin
      tx_t = -1; tx_busy = 1'b0; tx_done = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (tx_t >= 0) begin
        tx_t++;
        if (tx_t >= frame - 1) tx_busy = 1'b0;
        if (tx_t == frame) begin tx_done = 1'b1; tx_t = -1; end
      end
      if (tx_start) begin
        if (rand_tx) begin
          frame = int'($urandom_range(3, 8));
          short_mode = ($urandom_range(0, 5) == 0);
        end
        tx_t = 0;
        tx_busy = !short_mode;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    step();
  endtask

  task automatic set_byte(input int k, input logic [7:0] b);
    data[8*k +: 8] = b;
  endtask

  task automatic do_reset(input int cycles);
    req = '0; lock = '0; rst = 1'b0;
    repeat (cycles) cyc();
    rst = 1'b1;
  endtask

  task automatic wait_ack(input int k, input string tag);
    int n;
    n = 0;
    do begin cyc(); n++; end while (!ack[k] && n < 300);
    chk(tag, 32'(ack[k]), 1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    do begin cyc(); n++; end while (!tx_start && n < 300);
    chk(tag, 32'(tx_start), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin cyc(); n++; end while (sbusy && n < 300);
    chk(tag, 32'(sbusy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got[$];
    int g[$];
    int exp_g[4];
    int n, n0, c0;

    model_reset();
    repeat (3) cyc();
    chk("rst_cnt", 32'(bcnt), 0);
    chk("rst_busy", 32'(sbusy), 0);
    rst = 1'b1;

    // Single byte from requester 2.
    frame = 10; short_mode = 1'b0;
    set_byte(2, 8'h61); req[2] = 1'b1;
    wait_ack(2, "p1_ack");
    req[2] = 1'b0;
    wait_start("p1_start");
    chk("p1_data", 32'(tx_data), 32'h61);
    chk("p1_gid", 32'(gid), 2);
    wait_idle("p1_idle");
    chk("p1_cnt", 32'(bcnt), 1);

    // All four requesting: strict rotation from requester 0.
    do_reset(2);
    for (int k = 0; k < N; k++) set_byte(k, 8'(16 + k));
    req = '1;
    n = 0;
    while (n < 400 && got.size() < 5) begin
      cyc(); n++;
      if (tx_start) got.push_back(tx_data);
      if (ack != '0) chk("p2_ack_onehot", $countones(ack), 1);
    end
    req = '0;
    chk("p2_nstart", got.size(), 5);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("p2_byte%0d", i), 32'(got[i]), 32'(16 + i % 4));
    wait_idle("p2_idle");

    // Reset while waiting for done.
    set_byte(1, 8'h77); req[1] = 1'b1;
    wait_ack(1, "p3_ack");
    req[1] = 1'b0;
    wait_start("p3_start");
    repeat (3) cyc();
    chk("p3_busy_pre", 32'(sbusy), 1);
    do_reset(3);
    chk("p3_cnt_rst", 32'(bcnt), 0);
    chk("p3_ack_rst", 32'(ack), 0);
    set_byte(0, 8'hA0); set_byte(3, 8'hA3); req = 4'b1001;
    n = 0;
    do begin cyc(); n++; end while (ack == '0 && n < 300);
    chk("p3_first", 32'(ack), 32'h1);
    req[0] = 1'b0;
    wait_ack(3, "p3_second");
    req[3] = 1'b0;
    wait_idle("p3_idle");

    // Done without busy ever rising.
    short_mode = 1'b1; frame = 3;
    c0 = m_cnt;
    set_byte(2, 8'h5A); req[2] = 1'b1;
    wait_ack(2, "p4_ack");
    req[2] = 1'b0;
    wait_idle("p4_idle");
    chk("p4_cnt", 32'(bcnt), (c0 + 1) % (1 << CW));
    short_mode = 1'b0; frame = 6;
    set_byte(1, 8'h3C); req[1] = 1'b1;
    wait_ack(1, "p4_next");
    req[1] = 1'b0;
    wait_idle("p4_idle2");

    // Counter wrap with a 4-bit counter.
    do_reset(2);
    frame = 4;
    for (int i = 1; i <= 17; i++) begin
      set_byte(1, 8'($urandom)); req[1] = 1'b1;
      wait_ack(1, "p5_ack");
      req[1] = 1'b0;
      wait_idle("p5_idle");
      chk($sformatf("p5_cnt%0d", i), 32'(bcnt), i % 16);
    end

    // Grant hold: requester 0 sends 3 bytes with lock while requester 1 waits.
    do_reset(2);
    frame = 5;
    set_byte(0, 8'hC0); set_byte(1, 8'hB1);
    lock = 4'b0001; req = 4'b0011;
    n = 0; n0 = 0;
    while (n < 600 && g.size() < 4) begin
      cyc(); n++;
      if (ack[0]) begin
        g.push_back(0); n0++;
        if (n0 == 3) begin req[0] = 1'b0; lock[0] = 1'b0; end
        else set_byte(0, 8'(192 + n0));
      end
      if (ack[1]) g.push_back(1);
    end
    req = '0; lock = '0;
`ifdef UART_TX_SCHED_LOCK_EN
    exp_g = '{0, 0, 0, 1};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    chk("p6_ngrant", g.size(), 4);
    for (int i = 0; i < g.size() && i < 4; i++)
      chk($sformatf("p6_grant%0d", i), g[i], exp_g[i]);
    wait_idle("p6_idle");

    // Randomized producers, random frame lengths, one reset in the middle.
    do_reset(2);
    rand_tx = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (c == 1500) begin
        do_reset(2);
        continue;
      end
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          if (ack[k]) begin
            if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
            else set_byte(k, 8'($urandom));
          end else if ($urandom_range(0, 39) == 0) begin
            req[k] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_byte(k, 8'($urandom));
          req[k] = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) lock[k] = ~lock[k];
      end
    end
    req = '0; lock = '0;
    wait_idle("p7_idle");
    rand_tx = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
